vc_allocator: RTL and testbench



---
 rtl/vc_allocator.sv | 148 ++++++++++++++
 tb/tb_vc_allocator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vc_allocator.sv
`default_nettype none
// ============================================================================
// vc_allocator : registered 6x6 virtual-channel allocator, round-robin per
//                output VC, grant held for a whole wormhole packet.
// Revision     : 1.0
// ============================================================================
module vc_allocator #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] req_vc0,
  input  logic [5:0] req_vc1,
  input  logic [5:0] req_vc2,
  input  logic [5:0] req_vc3,
  input  logic [5:0] req_vc4,
  input  logic [5:0] req_vc5,
  input  logic [5:0] valid_in,
  input  logic [5:0] tail_in,
  input  logic [5:0] ready_in,
  output logic [5:0] selVCfromVC0,
  output logic [5:0] selVCfromVC1,
  output logic [5:0] selVCfromVC2,
  output logic [5:0] selVCfromVC3,
  output logic [5:0] selVCfromVC4,
  output logic [5:0] selVCfromVC5,
  output logic [5:0] out_busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam int         NUM_VC  = 6;
  localparam logic [2:0] PTR_RST = 3'(RR_INIT);

  logic [5:0] w_req    [NUM_VC];
  logic [5:0] w_qual   [NUM_VC];  // [output][input]
  logic [5:0] w_sel    [NUM_VC];  // [input][output]
  logic [2:0] w_owner  [NUM_VC];
  logic [5:0] w_locked;
  logic [5:0] w_owns;

  assign w_req[0] = req_vc0;
  assign w_req[1] = req_vc1;
  assign w_req[2] = req_vc2;
  assign w_req[3] = req_vc3;
  assign w_req[4] = req_vc4;
  assign w_req[5] = req_vc5;

  // Selects decode purely from registered state, so no input reaches an output.
  always_comb begin
    for (int n = 0; n < NUM_VC; n++) begin
      w_sel[n] = '0;
    end
    for (int o = 0; o < NUM_VC; o++) begin
      for (int n = 0; n < NUM_VC; n++) begin
        if (w_locked[o] && (w_owner[o] == 3'(n))) begin
          w_sel[n][o] = 1'b1;
        end
      end
    end
    for (int n = 0; n < NUM_VC; n++) begin
      w_owns[n] = |w_sel[n];
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_VC; o++) begin
      w_qual[o] = '0;
      for (int n = 0; n < NUM_VC; n++) begin
        w_qual[o][n] = valid_in[n] & $onehot(w_req[n]) & w_req[n][o] & ~w_owns[n];
      end
    end
  end

  for (genvar o = 0; o < NUM_VC; o++) begin : g_out
    state_t     state_q, state_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] w_winner;
    logic [3:0] w_idx;
    logic       w_found;
    logic       w_release;

    always_comb begin
      w_found  = 1'b0;
      w_winner = ptr_q;
      w_idx    = '0;
      for (int k = 0; k < NUM_VC; k++) begin
        w_idx = {1'b0, ptr_q} + 4'(k);
        if (w_idx >= 4'd6) begin
          w_idx = w_idx - 4'd6;
        end
        if (!w_found && w_qual[o][w_idx[2:0]]) begin
          w_found  = 1'b1;
          w_winner = w_idx[2:0];
        end
      end
    end

    assign w_release = valid_in[owner_q] & ready_in[o] & tail_in[owner_q];

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      case (state_q)
        IDLE: begin
          if (w_found) begin
            state_d = LOCKED;
            owner_d = w_winner;
            ptr_d   = (w_winner == 3'd5) ? 3'd0 : w_winner + 3'd1;
          end
        end
        LOCKED: begin
          if (w_release) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        owner_q <= '0;
        ptr_q   <= PTR_RST;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
      end
    end

    assign w_locked[o] = (state_q == LOCKED);
    assign w_owner[o]  = owner_q;
  end

  assign out_busy     = w_locked;
  assign selVCfromVC0 = w_sel[0];
  assign selVCfromVC1 = w_sel[1];
  assign selVCfromVC2 = w_sel[2];
  assign selVCfromVC3 = w_sel[3];
  assign selVCfromVC4 = w_sel[4];
  assign selVCfromVC5 = w_sel[5];

endmodule
`default_nettype wire

// File: tb/tb_vc_allocator.sv
`default_nettype none
// ============================================================================
// tb_vc_allocator : directed self-checking bench for vc_allocator.
// Revision        : 1.0
// ============================================================================
module tb_vc_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] req [6];
  logic [5:0] valid_in, tail_in, ready_in;
  logic [5:0] s0, s1, s2, s3, s4, s5, busy;
  logic [35:0] sel_flat;
  int total = 0;
  int bad   = 0;

  assign sel_flat = {s5, s4, s3, s2, s1, s0};

  vc_allocator #(.RR_INIT(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_vc0      (req[0]),
    .req_vc1      (req[1]),
    .req_vc2      (req[2]),
    .req_vc3      (req[3]),
    .req_vc4      (req[4]),
    .req_vc5      (req[5]),
    .valid_in     (valid_in),
    .tail_in      (tail_in),
    .ready_in     (ready_in),
    .selVCfromVC0 (s0),
    .selVCfromVC1 (s1),
    .selVCfromVC2 (s2),
    .selVCfromVC3 (s3),
    .selVCfromVC4 (s4),
    .selVCfromVC5 (s5),
    .out_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Select bit for input n owning output o inside the flattened select vector.
  function automatic logic [35:0] os(input int n, input int o);
    os = 36'd1 << (n * 6 + o);
  endfunction

  task automatic clear_inputs();
    valid_in = '0;
    tail_in  = '0;
    ready_in = '0;
    for (int n = 0; n < 6; n++) req[n] = '0;
  endtask

  initial begin
    int owners[3];
    int rdy[5];
    owners = '{1, 3, 4};
    rdy    = '{1, 0, 1, 1, 1};

    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("reset_sel", sel_flat, 36'd0);
    check("reset_busy", 36'(busy), 36'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_sel", sel_flat, 36'd0);
      check("idle_busy", 36'(busy), 36'd0);
    end

    // Single grant: input 0 -> output 2
    valid_in = 6'b000001;
    req[0]   = 6'b000100;
    tick();
    check("single_sel", sel_flat, os(0, 2));
    check("single_busy", 36'(busy), 36'b000100);
    tail_in  = 6'b000001;
    ready_in = 6'b000100;
    tick();
    clear_inputs();
    check("single_release", 36'(busy), 36'd0);
    tick();
    // Output 2 pointer is now 1: input 1 must beat input 0
    valid_in = 6'b000011;
    req[0]   = 6'b000100;
    req[1]   = 6'b000100;
    tick();
    check("ptr_after_grant", sel_flat, os(1, 2));
    tail_in  = 6'b000010;
    ready_in = 6'b000100;
    tick();
    clear_inputs();
    check("ptr_release", 36'(busy), 36'd0);
    tick();

    // Round-robin on output 5 with single-flit packets from inputs 1,3,4
    valid_in = 6'b011010;
    tail_in  = 6'b011010;
    ready_in = 6'b100000;
    req[1]   = 6'b100000;
    req[3]   = 6'b100000;
    req[4]   = 6'b100000;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i % 2 == 1) begin
        check("rr_sel", sel_flat, os(owners[((i - 1) / 2) % 3], 5));
        check("rr_busy", 36'(busy), 36'b100000);
      end else begin
        check("rr_gap", sel_flat, 36'd0);
      end
    end
    clear_inputs();
    tick();

    // Packet hold: input 2 wins output 0 over input 5, 4-flit packet
    valid_in = 6'b100100;
    req[2]   = 6'b000001;
    req[5]   = 6'b000001;
    tick();
    check("hold_grant", sel_flat, os(2, 0));
    for (int c = 1; c <= 5; c++) begin
      ready_in = rdy[c - 1] ? 6'b000001 : 6'b000000;
      tail_in  = (c == 5) ? 6'b000100 : 6'b000000;
      if (c == 2) req[2] = 6'b000010;
      tick();
      if (c < 5) begin
        check("hold_sel", sel_flat, os(2, 0));
        check("hold_busy", 36'(busy), 36'b000001);
      end else begin
        check("hold_release", sel_flat, 36'd0);
      end
    end
    valid_in = 6'b100000;
    tail_in  = '0;
    ready_in = '0;
    tick();
    check("hold_next_owner", sel_flat, os(5, 0));
    tail_in  = 6'b100000;
    ready_in = 6'b000001;
    tick();
    clear_inputs();
    check("hold_next_release", 36'(busy), 36'd0);
    tick();

    // Illegal multi-hot request is ignored until corrected
    valid_in = 6'b001000;
    req[3]   = 6'b010010;
    tick();
    check("illegal_busy", 36'(busy), 36'd0);
    tick();
    check("illegal_sel", sel_flat, 36'd0);
    req[3] = 6'b000010;
    tick();
    check("corrected_sel", sel_flat, os(3, 1));

    // Lock output 4 too, queue competitors, then reset mid-packet
    valid_in = 6'b101011;
    req[0]   = 6'b010000;
    req[1]   = 6'b000010;
    req[5]   = 6'b000010;
    tick();
    check("two_locks_sel", sel_flat, os(3, 1) | os(0, 4));
    check("two_locks_busy", 36'(busy), 36'b010010);
    rst = 1'b1;
    tick();
    check("midreset_sel", sel_flat, 36'd0);
    check("midreset_busy", 36'(busy), 36'd0);
    rst = 1'b0;
    tick();
    check("post_reset_sel", sel_flat, os(1, 1) | os(0, 4));
    check("post_reset_busy", 36'(busy), 36'b010010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
